pwr_cntr_bank: RTL

- Parametrised, synchronous bank of switching-activity (power) counters for gate-level characterisation benches.
- Counts rising edges on N_CH activity lines, each channel in its own counter.
- Provides atomic snapshot, saturate/wrap overflow modes with sticky flags, and a registered read/write port addressed by dir.
- Replaces hierarchical-reference counter increments. Library cells drive activity lines; benches read counts through the port.

---
 rtl/pwr_cntr_pkg.sv | 29 ++
 rtl/pwr_cntr_ch.sv | 93 +++++++++
 rtl/pwr_cntr_bank.sv | 93 +++++++++
 3 files changed

// File: rtl/pwr_cntr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwr_cntr_pkg
//  Description : Shared constants and helpers for the switching-activity
//                counter bank (default sizes, overflow-mode encodings, clog2).
//  Revision    : 1.0  initial release
// ============================================================================
package pwr_cntr_pkg;

   // Default geometry of the bank
   localparam int DEF_WIDTH = 32;
   localparam int DEF_N_CH  = 4;

   // Overflow-mode encodings for the SAT parameter
   localparam bit SAT_MODE  = 1'b1;
   localparam bit WRAP_MODE = 1'b0;

   // Number of address bits needed to select one of 'value' channels
   function automatic int clog2(input int value);
      int res;
      res = 0;
      while ((1 << res) < value) begin
         res = res + 1;
      end
      return res;
   endfunction

endpackage : pwr_cntr_pkg
`default_nettype wire

// File: rtl/pwr_cntr_ch.sv
`default_nettype none
// ============================================================================
//  Module      : pwr_cntr_ch
//  Description : One activity channel: rising-edge detector, live counter
//                with saturate/wrap overflow, sticky overflow flag and a
//                shadow register loaded on snapshot.
//  Revision    : 1.0  initial release
// ============================================================================
module pwr_cntr_ch
   import pwr_cntr_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter bit SAT         = SAT_MODE,
   parameter bit CLR_ON_SNAP = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enb,
   input  logic             act,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wdata,
   input  logic             snap,
   output logic [WIDTH-1:0] shadow,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

   logic             prev_act;
   logic             inc;
   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] count_nxt;
   logic             ovf_nxt;

   // A count event is a low-to-high transition seen while counting is enabled
   assign inc = enb & act & ~prev_act;

   // Activity history is tracked every cycle, so a line held high across
   // the enable rising does not produce a spurious count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_act <= 1'b0;
      end else begin
         prev_act <= act;
      end
   end

   // Next counter/flag value: increment, then snapshot clear, then write
   // (later assignments have priority, so a write always wins)
   always_comb begin
      count_nxt = count;
      ovf_nxt   = ovf;
      if (inc) begin
         if (count == CNT_MAX) begin
            ovf_nxt   = 1'b1;
            count_nxt = (SAT == SAT_MODE) ? CNT_MAX : '0;
         end else begin
            count_nxt = count + CNT_ONE;
         end
      end
      if (snap && CLR_ON_SNAP) begin
         // Event on the snapshot edge belongs to the new interval
         count_nxt = inc ? CNT_ONE : '0;
      end
      if (wr_en) begin
         count_nxt = wdata;
         ovf_nxt   = 1'b0;
      end
   end

   // Live counter and sticky overflow flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         ovf   <= 1'b0;
      end else begin
         count <= count_nxt;
         ovf   <= ovf_nxt;
      end
   end

   // Shadow captures the live value as it stood before this edge's update
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow <= '0;
      end else if (snap) begin
         shadow <= count;
      end
   end

endmodule : pwr_cntr_ch
`default_nettype wire

// File: rtl/pwr_cntr_bank.sv
`default_nettype none
// ============================================================================
//  Module      : pwr_cntr_bank
//  Description : Bank of N_CH switching-activity counters with atomic
//                snapshot into shadow registers and a registered
//                read/write port addressed by dir.
//  Revision    : 1.0  initial release
// ============================================================================
module pwr_cntr_bank
   import pwr_cntr_pkg::*;
#(
   parameter int N_CH        = DEF_N_CH,
   parameter int WIDTH       = DEF_WIDTH,
   parameter int ADDR_W      = 2,
   parameter bit SAT         = SAT_MODE,
   parameter bit CLR_ON_SNAP = 1'b0
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              ENB,
   input  logic [N_CH-1:0]   act,
   input  logic [ADDR_W-1:0] dir,
   input  logic              LE,
   input  logic              WE,
   input  logic [WIDTH-1:0]  wdata,
   input  logic              SNAP,
   output logic [WIDTH-1:0]  rdata,
   output logic              rvalid,
   output logic [N_CH-1:0]   ovf
);

   // Reject parameter sets the address decode or counters cannot support
   generate
      if (ADDR_W < clog2(N_CH)) begin : g_addr_w_check
         $error("pwr_cntr_bank: ADDR_W too narrow to address N_CH channels");
      end
      if ((N_CH < 1) || (N_CH > 64) || (WIDTH < 8) || (WIDTH > 32)) begin : g_range_check
         $error("pwr_cntr_bank: N_CH or WIDTH out of supported range");
      end
   endgenerate

   logic [WIDTH-1:0] shadow [N_CH];
   logic [WIDTH-1:0] rd_mux;

   // One counter channel per activity line; writes decode dir per channel
   generate
      for (genvar i = 0; i < N_CH; i++) begin : g_ch
         logic wr_en;
         assign wr_en = WE && (int'(dir) == i);

         pwr_cntr_ch #(
            .WIDTH       (WIDTH),
            .SAT         (SAT),
            .CLR_ON_SNAP (CLR_ON_SNAP)
         ) u_ch (
            .clk    (CLK),
            .rst    (RST),
            .enb    (ENB),
            .act    (act[i]),
            .wr_en  (wr_en),
            .wdata  (wdata),
            .snap   (SNAP),
            .shadow (shadow[i]),
            .ovf    (ovf[i])
         );
      end
   endgenerate

   // Shadow select; unpopulated addresses read as zero
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (int'(dir) == i) begin
            rd_mux = shadow[i];
         end
      end
   end

   // Single registered read stage: rvalid pulses per strobe, rdata holds
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rdata  <= '0;
         rvalid <= 1'b0;
      end else begin
         rvalid <= LE;
         if (LE) begin
            rdata <= rd_mux;
         end
      end
   end

endmodule : pwr_cntr_bank
`default_nettype wire
